// File: rtl/data_mem_responder.sv
// Fixed-latency, in-order data memory responder for the LSU issue port.
// Optional: define MEM_RESP_MISALIGN_CHECK_EN to flag misaligned ops instead of executing them.
module data_mem_responder #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 5,
  parameter int MEM_DEPTH     = 256,
  parameter int LATENCY       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fire_memory_op,
  input  logic                         memory_op_type,
  input  logic [XLEN-1:0]              memory_address,
  input  logic [XLEN-1:0]              memory_data,
  input  logic [ROB_TAG_WIDTH-1:0]     memory_rob_tag,
  input  logic                         kill_mem_req,
  input  logic                         mem_stall,
  output logic                         mem_ready,
  output logic                         load_succeeded,
  output logic [ROB_TAG_WIDTH-1:0]     load_succeeded_rob_tag,
  output logic [XLEN-1:0]              load_data,
  output logic                         store_succeeded,
  output logic [ROB_TAG_WIDTH-1:0]     store_succeeded_rob_tag,
`ifdef MEM_RESP_MISALIGN_CHECK_EN
  output logic                         mem_misaligned,
  output logic [ROB_TAG_WIDTH-1:0]     mem_misaligned_rob_tag,
`endif
  output logic [$clog2(LATENCY+1)-1:0] ops_in_flight
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(LATENCY+1);
  localparam int F     = LATENCY - 1;

  logic [LATENCY-1:0]       r_vld;
  logic [LATENCY-1:0]       r_type;
  logic [XLEN-1:0]          r_addr [LATENCY];
  logic [XLEN-1:0]          r_data [LATENCY];
  logic [ROB_TAG_WIDTH-1:0] r_tag  [LATENCY];
  logic [XLEN-1:0]          r_mem  [MEM_DEPTH];
  logic [XLEN-1:0]          r_rd_data;

  logic             w_in_vld;
  logic             w_x_vld;
  logic             w_x_type;
  logic [XLEN-1:0]  w_x_addr;
  logic [XLEN-1:0]  w_x_data;
  logic [IDX_W-1:0] w_x_idx;
  logic             w_x_mis;
  logic             w_f_mis;
  logic             w_exec;
  logic             w_f_live;
  logic             w_unused;

  assign mem_ready = !mem_stall;
  // A killed load still occupies stage 0, just as a bubble.
  assign w_in_vld  = fire_memory_op && !(kill_mem_req && !memory_op_type);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld <= '0;
    end else if (!mem_stall) begin
      r_vld[0] <= w_in_vld;
      for (int i = 1; i < LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!mem_stall) begin
      r_type[0] <= memory_op_type;
      r_addr[0] <= memory_address;
      r_data[0] <= memory_data;
      r_tag[0]  <= memory_rob_tag;
      for (int i = 1; i < LATENCY; i++) begin
        r_type[i] <= r_type[i-1];
        r_addr[i] <= r_addr[i-1];
        r_data[i] <= r_data[i-1];
        r_tag[i]  <= r_tag[i-1];
      end
    end
  end

  // The array is accessed on the edge that moves an op into the final stage,
  // so its response (and registered read data) is visible while it sits there.
  generate
    if (LATENCY == 1) begin : g_direct
      assign w_x_vld  = w_in_vld;
      assign w_x_type = memory_op_type;
      assign w_x_addr = memory_address;
      assign w_x_data = memory_data;
    end else begin : g_staged
      assign w_x_vld  = r_vld[LATENCY-2];
      assign w_x_type = r_type[LATENCY-2];
      assign w_x_addr = r_addr[LATENCY-2];
      assign w_x_data = r_data[LATENCY-2];
    end
  endgenerate

`ifdef MEM_RESP_MISALIGN_CHECK_EN
  assign w_x_mis = |w_x_addr[1:0];
  assign w_f_mis = |r_addr[F][1:0];
`else
  assign w_x_mis = 1'b0;
  assign w_f_mis = 1'b0;
`endif

  assign w_x_idx = w_x_addr[IDX_W+1:2];
  assign w_exec  = reset && !mem_stall && w_x_vld && !w_x_mis;

  always_ff @(posedge clk) begin
    if (w_exec && w_x_type) r_mem[w_x_idx] <= w_x_data;
    if (w_exec && !w_x_type) r_rd_data <= r_mem[w_x_idx];
  end

  assign w_f_live                = r_vld[F] && !mem_stall;
  assign load_succeeded          = w_f_live && !w_f_mis && !r_type[F];
  assign store_succeeded         = w_f_live && !w_f_mis && r_type[F];
  assign load_succeeded_rob_tag  = load_succeeded ? r_tag[F] : '0;
  assign store_succeeded_rob_tag = store_succeeded ? r_tag[F] : '0;
  assign load_data               = load_succeeded ? r_rd_data : '0;
`ifdef MEM_RESP_MISALIGN_CHECK_EN
  assign mem_misaligned          = w_f_live && w_f_mis;
  assign mem_misaligned_rob_tag  = mem_misaligned ? r_tag[F] : '0;
`endif

  always_comb begin
    ops_in_flight = '0;
    for (int i = 0; i < LATENCY; i++) ops_in_flight = ops_in_flight + CNT_W'(r_vld[i]);
  end

  assign w_unused = ^{w_x_addr[XLEN-1:IDX_W+2], w_x_addr[1:0], r_addr[F], r_data[F]};
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized + directed bench for data_mem_responder against a queue-based latency/memory model.
module tb_data_mem_responder;
  localparam int XLEN  = 32;
  localparam int TW    = 5;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int CW    = $clog2(LAT+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, fire, op_type, kill, stall;
  logic [XLEN-1:0] addr, wdata;
  logic [TW-1:0]   tag;
  logic            mem_ready, load_ok, store_ok;
  logic [TW-1:0]   load_tag, store_tag;
  logic [XLEN-1:0] load_data;
  logic [CW-1:0]   in_flight;
`ifdef MEM_RESP_MISALIGN_CHECK_EN
  logic            mis;
  logic [TW-1:0]   mis_tag;
`endif

  data_mem_responder #(.XLEN(XLEN), .ROB_TAG_WIDTH(TW), .MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .fire_memory_op(fire), .memory_op_type(op_type), .memory_address(addr),
    .memory_data(wdata), .memory_rob_tag(tag), .kill_mem_req(kill), .mem_stall(stall),
    .mem_ready(mem_ready),
    .load_succeeded(load_ok), .load_succeeded_rob_tag(load_tag), .load_data(load_data),
    .store_succeeded(store_ok), .store_succeeded_rob_tag(store_tag),
`ifdef MEM_RESP_MISALIGN_CHECK_EN
    .mem_misaligned(mis), .mem_misaligned_rob_tag(mis_tag),
`endif
    .ops_in_flight(in_flight)
  );

  // An accepted op completes once it has seen LAT unstalled edges (counting its accept edge).
  typedef struct {
    bit          st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  tag;
    int          age;
  } op_t;

  op_t         pend[$];
  logic [31:0] ref_mem [int];
  int          tests_run    = 0;
  int          tests_failed = 0;

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick(input bit f, input bit t, input logic [31:0] a, input logic [31:0] d,
                      input logic [4:0] tg, input bit k, input bit s, input bit rst_n);
    logic [31:0] e_ld, e_lt, e_ldata, e_st, e_stag, e_oif;
    bit          skip, data_known;
    op_t         head;
    int          w;
`ifdef MEM_RESP_MISALIGN_CHECK_EN
    logic [31:0] e_mis, e_mtag;
    e_mis = 0; e_mtag = 0;
`endif
    fire = f; op_type = t; addr = a; wdata = d; tag = tg; kill = k; stall = s; reset = rst_n;
    e_ld = 0; e_lt = 0; e_ldata = 0; e_st = 0; e_stag = 0;
    e_oif = pend.size();
    skip = 1'b0; data_known = 1'b1;
    if (!s && pend.size() != 0 && pend[0].age == LAT) begin
      head = pend.pop_front();
      w = word_of(head.addr);
`ifdef MEM_RESP_MISALIGN_CHECK_EN
      if (head.addr[1:0] != 2'b00) begin
        skip = 1'b1; e_mis = 1; e_mtag = 32'(head.tag);
      end
`endif
      if (!skip && head.st) begin
        ref_mem[w] = head.data; e_st = 1; e_stag = 32'(head.tag);
      end else if (!skip) begin
        e_ld = 1; e_lt = 32'(head.tag);
        data_known = ref_mem.exists(w);
        if (data_known) e_ldata = ref_mem[w];
      end
    end
    @(negedge clk);
    chk("mem_ready", 32'(mem_ready), 32'(!s));
    chk("load_succeeded", 32'(load_ok), e_ld);
    chk("load_tag", 32'(load_tag), e_lt);
    if (data_known) chk("load_data", load_data, e_ldata);
    chk("store_succeeded", 32'(store_ok), e_st);
    chk("store_tag", 32'(store_tag), e_stag);
    chk("ops_in_flight", 32'(in_flight), e_oif);
`ifdef MEM_RESP_MISALIGN_CHECK_EN
    chk("mem_misaligned", 32'(mis), e_mis);
    chk("misaligned_tag", 32'(mis_tag), e_mtag);
`endif
    if (!rst_n) begin
      pend.delete();
    end else if (!s) begin
      foreach (pend[i]) pend[i].age++;
      if (f && !(k && !t)) pend.push_back('{t, a, d, tg, 1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  int unsigned rr;
  logic [31:0] ra;

  initial begin
    reset = 0; fire = 0; op_type = 0; addr = 0; wdata = 0; tag = 0; kill = 0; stall = 0;
    repeat (2) @(posedge clk);
    #1;
    tick(0, 0, 0, 0, 0, 0, 0, 0);

    for (int w = 0; w < 16; w++) tick(1, 1, 32'(w * 4), $urandom, 5'(w), 0, 0, 1);
    idle(3);

    // Store then load at 0x10.
    tick(1, 1, 32'h10, 32'hDEAD_BEEF, 5'd3, 0, 0, 1);
    idle(2);
    tick(1, 0, 32'h10, 0, 5'd4, 0, 0, 1);
    idle(2);

    // Back-to-back store/load to the same word.
    tick(1, 1, 32'h20, 32'h11, 5'd5, 0, 0, 1);
    tick(1, 0, 32'h20, 0, 5'd6, 0, 0, 1);
    idle(3);

    // Killed load vanishes; kill alongside a store is ignored.
    tick(1, 0, 32'h30, 0, 5'd7, 1, 0, 1);
    tick(1, 1, 32'h30, 32'h77, 5'd8, 1, 0, 1);
    tick(0, 0, 0, 0, 0, 1, 0, 1);
    idle(3);

    // Stall with two ops in flight, one refused request during the stall.
    tick(1, 1, 32'h34, 32'hCAFE_0001, 5'd9, 0, 0, 1);
    tick(1, 0, 32'h34, 0, 5'd10, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 1, 1);
    tick(1, 1, 32'h38, 32'hBAD0_BAD0, 5'd15, 0, 1, 1);
    tick(0, 0, 0, 0, 0, 0, 1, 1);
    idle(3);

    // Address wrap-around.
    tick(1, 1, 32'h400, 32'h55, 5'd11, 0, 0, 1);
    tick(1, 0, 32'h000, 0, 5'd12, 0, 0, 1);
    idle(3);

    // Misaligned load.
    tick(1, 0, 32'h13, 0, 5'd7, 0, 0, 1);
    idle(3);

    // Reset with two ops in flight.
    tick(1, 1, 32'h08, 32'h1234_5678, 5'd13, 0, 0, 1);
    tick(1, 0, 32'h08, 0, 5'd14, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    for (int n = 0; n < 400; n++) begin
      rr = $urandom_range(99);
      ra = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
      tick(rr < 70, 1'($urandom_range(1)), ra, $urandom, 5'($urandom),
           $urandom_range(99) < 15, $urandom_range(99) < 15, $urandom_range(99) >= 2);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
